config_chain_loader: RTL and testbench

Bitstream shift driver for the configuration chain built from DFFSRQ cells. It accepts configuration words from the programming host over a valid/ready stream, serializes them MSB-first into the chain head and generates the programming clock. It stops after exactly CHAIN_LEN bits. An optional readback path captures the bits leaving the chain tail, which hold the previous configuration, and returns them as words.

---
 rtl/config_chain_loader_if.sv | 21 ++
 rtl/config_chain_loader.sv | 142 ++++++++++++++
 tb/tb_config_chain_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_loader_if.sv
// Host-side stream for the configuration chain loader: word input with valid/ready
// and the readback word strobe coming back.
interface config_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output din, din_valid,
    input  din_ready, rb_data, rb_valid
  );

  modport slave (
    input  din, din_valid,
    output din_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/config_chain_loader.sv
// Serialises host words MSB-first into a DFFSRQ configuration chain, stopping after CHAIN_LEN bits.
// Define CONFIG_CHAIN_READBACK_EN to return the previous chain contents from ccff_tail as words.
module config_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 start,
  config_chain_loader_if.slave host,
  output logic                 ccff_head,
  output logic                 prog_ck,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done
);
  // state    | meaning
  // IDLE     | after reset, waiting for start
  // LOAD     | din_ready high, waiting for a host word
  // SHIFT_LO | prog_ck low, ccff_head presents the current bit
  // SHIFT_HI | prog_ck high (chain captures), then advance counters
  // DONE     | CHAIN_LEN bits shifted, waiting for start

  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  total, total_nxt;
  logic [BW-1:0]     biw, biw_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              head_nxt;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      total     <= '0;
      biw       <= '0;
      shreg     <= '0;
      ccff_head <= 1'b0;
      prog_ck   <= 1'b0;
    end else begin
      state     <= state_nxt;
      total     <= total_nxt;
      biw       <= biw_nxt;
      shreg     <= shreg_nxt;
      ccff_head <= head_nxt;
      prog_ck   <= (state_nxt == ST_SHIFT_HI);
    end
  end

  // ccff_head only changes on entry to SHIFT_LO, so it is steady across both prog_ck phases
  always_comb begin
    state_nxt = state;
    total_nxt = total;
    biw_nxt   = biw;
    shreg_nxt = shreg;
    head_nxt  = ccff_head;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          total_nxt = '0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (host.din_valid) begin
          shreg_nxt = host.din;
          biw_nxt   = '0;
          head_nxt  = host.din[WORD_W-1];
          state_nxt = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        total_nxt = total + CNT_W'(1);
        biw_nxt   = biw + BW'(1);
        shreg_nxt = shreg << 1;
        if (total_nxt == CNT_W'(CHAIN_LEN)) begin
          state_nxt = ST_DONE;
        end else if (biw_nxt == BW'(WORD_W)) begin
          state_nxt = ST_LOAD;
        end else begin
          head_nxt  = shreg_nxt[WORD_W-1];
          state_nxt = ST_SHIFT_LO;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign host.din_ready = (state == ST_LOAD);
  assign busy = (state == ST_LOAD) || (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
  assign done = (state == ST_DONE);

`ifdef CONFIG_CHAIN_READBACK_EN
  logic [WORD_W-1:0] rb_sh, rb_data_q;
  logic              rb_valid_q;
  logic [BW-1:0]     rb_pos;

  // readback words share the input word alignment; a short final word stays zero in its LSBs
  assign rb_pos = BW'(WORD_W - 1) - biw;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      rb_sh      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (state == ST_LOAD && host.din_valid) begin
        rb_sh <= '0;
      end else if (state == ST_SHIFT_LO) begin
        rb_sh <= rb_sh | (WORD_W'(ccff_tail) << rb_pos);
      end
      if (state == ST_SHIFT_HI &&
          (total_nxt == CNT_W'(CHAIN_LEN) || biw_nxt == BW'(WORD_W))) begin
        rb_data_q  <= rb_sh;
        rb_valid_q <= 1'b1;
      end
    end
  end

  assign host.rb_data  = rb_data_q;
  assign host.rb_valid = rb_valid_q;
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign host.rb_data  = '0;
  assign host.rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: models the DFFSRQ chain, drives host words, checks the
// shifted stream, timing, control corner cases and (in the readback build) returned words.
module tb_config_chain_loader;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 12;

  logic ck = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ccff_head, prog_ck, ccff_tail, busy, done;

  config_chain_loader_if #(.WORD_W(WORD_W)) hif ();

  config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .ck        (ck),
    .rst       (rst),
    .start     (start),
    .host      (hif),
    .ccff_head (ccff_head),
    .prog_ck   (prog_ck),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done)
  );

  always #5 ck = ~ck;

  // chain model: chain[0] is the head flop, chain[CHAIN_LEN-1] drives the tail
  logic [CHAIN_LEN-1:0] chain = '0;
  int rises = 0;
  always @(posedge prog_ck) begin
    chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    rises <= rises + 1;
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  logic [WORD_W-1:0] rbq[$];
  always @(negedge ck) if (hif.rb_valid) rbq.push_back(hif.rb_data);

  int n_pass = 0;
  int n_total = 0;
  logic [CHAIN_LEN-1:0] prev_stream = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [WORD_W-1:0]    w0;
    logic [WORD_W-1:0]    w1;
    int                   g0;
    int                   g1;
    bit                   poke;
    logic [CHAIN_LEN-1:0] exp_head;
    int                   exp_lat;
  } vec_t;

  task automatic run_load(input string tag, input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                          input int g0, input int g1, input bit poke,
                          input logic [CHAIN_LEN-1:0] exp_head, input int exp_lat, input bit chk_rb);
    logic [WORD_W-1:0] words[2];
    int gaps[2];
    int idx = 0;
    int n = 0;
    int r0, r1, gap_left;
    bit gap_ok = 1'b1;
    bit poked = 1'b0;
    words[0] = w0; words[1] = w1;
    gaps[0] = g0; gaps[1] = g1;
    r0 = rises;
    rbq.delete();
    @(negedge ck); start = 1'b1;
    @(posedge ck);
    @(negedge ck); start = 1'b0;
    check($sformatf("%s done/ready after start", tag), {30'd0, done, hif.din_ready}, 32'd1);
    gap_left = gaps[0];
    while (!done && n < 400) begin
      start = 1'b0;
      if (hif.din_ready) begin
        if (prog_ck) gap_ok = 1'b0;
        if (gap_left > 0 || idx > 1) begin
          hif.din_valid = 1'b0;
          hif.din = WORD_W'($urandom);
          if (gap_left > 0) gap_left--;
        end else begin
          hif.din_valid = 1'b1;
          hif.din = words[idx];
          idx++;
          if (idx < 2) gap_left = gaps[idx];
        end
      end else begin
        hif.din_valid = 1'($urandom_range(0, 1));
        hif.din = WORD_W'($urandom);
        if (poke && !poked && prog_ck) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end
      @(posedge ck); n++;
      @(negedge ck);
    end
    start = 1'b0;
    hif.din_valid = 1'b0;
    check($sformatf("%s done latency", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s prog_ck rises", tag), 32'(rises - r0), 32'(CHAIN_LEN));
    check($sformatf("%s chain contents", tag), 32'(chain), 32'(exp_head));
    check($sformatf("%s prog_ck low in load", tag), 32'(gap_ok), 32'd1);
    r1 = rises;
    repeat (3) begin
      hif.din_valid = 1'($urandom_range(0, 1));
      @(negedge ck);
    end
    hif.din_valid = 1'b0;
    check($sformatf("%s done held", tag), {29'd0, done, busy, hif.din_ready}, 32'd4);
    check($sformatf("%s no extra rises", tag), 32'(rises - r1), 32'd0);
`ifdef CONFIG_CHAIN_READBACK_EN
    if (chk_rb) begin
      check($sformatf("%s readback count", tag), 32'(rbq.size()), 32'd2);
      if (rbq.size() >= 2) begin
        check($sformatf("%s readback word0", tag), 32'(rbq[0]), 32'(prev_stream[11:4]));
        check($sformatf("%s readback word1", tag), 32'(rbq[1]), {24'd0, prev_stream[3:0], 4'b0000});
      end
    end
`else
    check($sformatf("%s no readback strobes", tag), 32'(rbq.size()), 32'd0);
    check($sformatf("%s readback data tied", tag), 32'(hif.rb_data), 32'd0);
    if (chk_rb) prev_stream = '0;
`endif
    prev_stream = exp_head;
  endtask

  vec_t tbl[5];

  initial begin
    logic [2*WORD_W-1:0] cat;
    logic [WORD_W-1:0] rw0, rw1;
    int rg0, rg1, wait_n;
    bit stayed_low;

    tbl[0] = '{8'hA5, 8'h3C, 0, 0, 1'b0, 12'hA53, 26};
    tbl[1] = '{8'hFF, 8'h0F, 0, 0, 1'b0, 12'hFF0, 26};
    tbl[2] = '{8'h5A, 8'hC3, 5, 0, 1'b0, 12'h5AC, 31};
    tbl[3] = '{8'h00, 8'hFF, 0, 2, 1'b1, 12'h00F, 28};
    tbl[4] = '{8'hC3, 8'h5A, 1, 1, 1'b1, 12'hC35, 28};

    hif.din = '0;
    hif.din_valid = 1'b0;
    repeat (2) @(negedge ck);
    check("reset outputs", {18'd0, busy, done, hif.din_ready, prog_ck, ccff_head, hif.rb_valid, hif.rb_data},
          32'd0);
    rst = 1'b1;
    stayed_low = 1'b1;
    repeat (5) begin
      hif.din_valid = 1'b1;
      hif.din = WORD_W'($urandom);
      @(negedge ck);
      if (hif.din_ready || busy || prog_ck) stayed_low = 1'b0;
    end
    hif.din_valid = 1'b0;
    check("idle without start", 32'(stayed_low), 32'd1);

    for (int i = 0; i < 5; i++)
      run_load($sformatf("vec%0d", i), tbl[i].w0, tbl[i].w1, tbl[i].g0, tbl[i].g1, tbl[i].poke,
               tbl[i].exp_head, tbl[i].exp_lat, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rw0 = WORD_W'($urandom);
      rw1 = WORD_W'($urandom);
      rg0 = $urandom_range(0, 4);
      rg1 = $urandom_range(0, 4);
      cat = {rw0, rw1};
      run_load($sformatf("rnd%0d", i), rw0, rw1, rg0, rg1, 1'($urandom_range(0, 1)),
               cat[2*WORD_W-1 -: CHAIN_LEN], 2 * CHAIN_LEN + 2 + rg0 + rg1, 1'b1);
    end

    // reset in the middle of a shift
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    hif.din_valid = 1'b1;
    hif.din = 8'hFF;
    wait_n = 0;
    while (!prog_ck && wait_n < 20) begin
      @(negedge ck);
      wait_n++;
    end
    check("reach shift_hi", 32'(prog_ck & ccff_head), 32'd1);
    rst = 1'b0;
    #1;
    check("async reset outputs", {18'd0, busy, done, hif.din_ready, prog_ck, ccff_head, hif.rb_valid,
          hif.rb_data}, 32'd0);
    repeat (2) @(negedge ck);
    rst = 1'b1;
    stayed_low = 1'b1;
    repeat (4) begin
      @(negedge ck);
      if (hif.din_ready || busy || done) stayed_low = 1'b0;
    end
    hif.din_valid = 1'b0;
    check("idle after reset release", 32'(stayed_low), 32'd1);

    run_load("post_reset", 8'h96, 8'h71, 0, 3, 1'b0, 12'h967, 29, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
